// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared CPU constants used by the fetch buffer.
package fetch_queue_pkg;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] PC_RESET       = 32'h0000_3000;
  localparam logic [31:0] PC_LINK_OFFSET = 32'd8;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of fetched (pc, instr) pairs feeding ID, with PC back-pressure and redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   instr_in,
  output logic          pc_en,
  input  logic          flush,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_instr,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_pc8,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, enq, deq;
  logic [63:0]   head;
  assign full     = count == CW'(DEPTH);
  assign id_valid = count != '0;
  // A full queue refuses to enqueue even while draining, keeping id_ready off the pc_en path.
  assign enq      = !full && !flush;
  assign deq      = id_valid && id_ready && !flush;
  assign pc_en    = !full || flush;
  assign head     = mem[rd_ptr];
  always_comb begin
    id_pc    = id_valid ? head[63:32] : '0;
    id_instr = id_valid ? head[31:0] : NOP_INSTR;
    id_pc8   = id_valid ? head[63:32] + PC_LINK_OFFSET : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
  end
  always_ff @(posedge clk)
    if (enq) mem[wr_ptr] <= {pc_in, instr_in};
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 0, reset = 0, flush = 0, id_ready = 0;
  logic [31:0] pc_in = 0, instr_in = 0;
  logic pc_en, id_valid;
  logic [31:0] id_instr, id_pc, id_pc8;
  logic [CW-1:0] count;
  int checks = 0, errors = 0;
  logic [63:0] q[$];
  logic [31:0] last_pc;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in), .pc_en(pc_en),
    .flush(flush), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc8(id_pc8), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] epc, einstr;
    epc    = q.size() > 0 ? q[0][63:32] : 32'h0;
    einstr = q.size() > 0 ? q[0][31:0] : 32'h0;
    chk("count", 32'(count), q.size());
    chk("id_valid", 32'(id_valid), 32'(q.size() > 0));
    chk("id_pc", id_pc, epc);
    chk("id_instr", id_instr, einstr);
    chk("id_pc8", id_pc8, q.size() > 0 ? epc + 32'd8 : 32'h0);
    chk("pc_en", 32'(pc_en), 32'(q.size() < DEPTH || flush));
  endtask

  task automatic step(input logic f, input logic r, input logic [31:0] p, input logic [31:0] i);
    int n;
    flush = f; id_ready = r; pc_in = p; instr_in = i;
    #1 check_model();
    @(posedge clk);
    n = q.size();
    if (f) q.delete();
    else begin
      if (n > 0 && r) void'(q.pop_front());
      if (n < DEPTH) q.push_back({p, i});
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc8", id_pc8, 0);
    chk("rst_pc_en", 32'(pc_en), 1);
    reset = 1;
    for (int k = 0; k < 4; k++) step(0, 0, 32'h3000 + 32'(4 * k), 32'h24010001 + 32'(k));
    #1;
    chk("fill_count", 32'(count), 4);
    chk("fill_pc_en", 32'(pc_en), 0);
    chk("fill_id_pc", id_pc, 32'h3000);
    chk("fill_id_pc8", id_pc8, 32'h3008);
    chk("fill_id_instr", id_instr, 32'h24010001);
    step(0, 1, 32'h3010, 32'h24010005);
    #1;
    chk("drain_count", 32'(count), 3);
    chk("drain_id_pc", id_pc, 32'h3004);
    chk("drain_pc_en", 32'(pc_en), 1);
    step(0, 0, 32'h3010, 32'h24010005);
    #1 chk("refill_count", 32'(count), 4);
    step(1, 0, 32'h0, 32'h0);
    step(0, 0, 32'h3200, 32'h11111111);
    step(0, 0, 32'h3204, 32'h11111112);
    last_pc = 32'h3200 - 32'd4;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("steady_count", 32'(count), 2);
      chk("steady_seq", id_pc, last_pc + 32'd4);
      last_pc = id_pc;
      step(0, 1, 32'h3208 + 32'(4 * k), 32'h22220000 + 32'(k));
    end
    step(1, 0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) step(0, 0, 32'h3010 + 32'(4 * k), 32'h33330000 + 32'(k));
    flush = 1; pc_in = 32'h3020;
    #1 chk("flush_pc_en", 32'(pc_en), 1);
    step(1, 0, 32'h3020, 32'h44440000);
    #1;
    chk("post_flush_count", 32'(count), 0);
    chk("post_flush_valid", 32'(id_valid), 0);
    step(0, 0, 32'h3100, 32'h55550000);
    #1 chk("redirect_pc", id_pc, 32'h3100);
    for (int k = 0; k < 3; k++) step(0, 0, 32'h3104 + 32'(4 * k), 32'h55550001 + 32'(k));
    #1 chk("full_before_flush", 32'(count), 4);
    step(1, 1, 32'h3500, 32'h0);
    #1 chk("flush_wins_count", 32'(count), 0);
    for (int k = 0; k < 3; k++) step(0, 0, 32'h3600 + 32'(4 * k), 32'h66660000 + 32'(k));
    #2 reset = 0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_valid", 32'(id_valid), 0);
    chk("async_instr", id_instr, 0);
    chk("async_pc", id_pc, 0);
    chk("async_pc_en", 32'(pc_en), 1);
    q.delete();
    @(negedge clk);
    reset = 1;
    for (int k = 0; k < 300; k++)
      step($urandom_range(7) == 0, 1'($urandom), $urandom, $urandom);
    #1 check_model();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
